// File: rtl/sram_write_buffer.sv
// sram_write_buffer: posted-write FIFO in front of the SRAM controller.
// Optional store coalescing into the youngest entry: define WBUF_COALESCE_EN.
module sram_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_in,
    input  logic                       rd_en_in,
    input  logic [ADDR_W-1:0]          address_in,
    input  logic [DATA_W-1:0]          write_data_in,
    output logic                       ready_out,
    output logic [63:0]                read_data_out,
    output logic                       sram_wr_en_out,
    output logic                       sram_rd_en_out,
    output logic [ADDR_W-1:0]          sram_address_out,
    output logic [DATA_W-1:0]          sram_write_data_out,
    input  logic [63:0]                sram_read_data_in,
    input  logic                       sram_ready_in,
    output logic [$clog2(DEPTH):0]     wbuf_count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    logic rd_only;
    logic push;
    logic pop;
    logic coal_hit;
    logic rd_done;

    // A read is only considered when no store is asserted alongside it.
    assign rd_only = rd_en_in & ~wr_en_in;

`ifdef WBUF_COALESCE_EN
    logic [PTR_W-1:0] young_ptr;
    assign young_ptr = tail_q - PTR_W'(1);
    // Merge into the youngest entry unless it is the head on the SRAM bus.
    assign coal_hit  = wr_en_in
                     && (count_q != '0)
                     && (addr_mem_q[young_ptr] == address_in)
                     && !((state_q == DRAIN) && (count_q == CNT_W'(1)));
`else
    assign coal_hit  = 1'b0;
`endif

    // Full blocks a push even if the head pops on the same edge.
    assign push    = wr_en_in & ~coal_hit & (count_q != FULL_CNT);
    assign pop     = (state_q == DRAIN) & sram_ready_in;
    assign rd_done = (state_q == READ) & sram_ready_in & rd_only;

    assign ready_out      = rst_n & (push | coal_hit | rd_done);
    assign read_data_out  = sram_read_data_in;
    assign wbuf_count_out = count_q;

    // FIFO storage, pointer and occupancy next-state.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[tail_q] = address_in;
            data_mem_d[tail_q] = write_data_in;
            tail_d             = tail_q + PTR_W'(1);
        end
`ifdef WBUF_COALESCE_EN
        if (coal_hit) begin
            data_mem_d[young_ptr] = write_data_in;
        end
`endif
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain/read sequencing and SRAM-side outputs decoded from state.
    always_comb begin
        state_d             = state_q;
        sram_wr_en_out      = 1'b0;
        sram_rd_en_out      = 1'b0;
        sram_address_out    = '0;
        sram_write_data_out = '0;
        unique case (state_q)
            IDLE: begin
                if (count_d != '0) begin
                    state_d = DRAIN;
                end else if (rd_only) begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                sram_wr_en_out      = 1'b1;
                sram_address_out    = addr_mem_q[head_q];
                sram_write_data_out = data_mem_q[head_q];
                if (pop) begin
                    if (count_d != '0) begin
                        state_d = DRAIN;
                    end else if (rd_only) begin
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                sram_rd_en_out   = 1'b1;
                sram_address_out = address_in;
                if (sram_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointers, occupancy and entry storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_sram_write_buffer.sv
// tb_sram_write_buffer: directed vectors plus multi-cycle sequences.
// Expected values are hand-derived; build with WBUF_COALESCE_EN for coalescing.
module tb_sram_write_buffer;

    logic        clk;
    logic        rst_n;
    logic        wr_en_in;
    logic        rd_en_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic        ready_out;
    logic [63:0] read_data_out;
    logic        sram_wr_en_out;
    logic        sram_rd_en_out;
    logic [31:0] sram_address_out;
    logic [31:0] sram_write_data_out;
    logic [63:0] sram_read_data_in;
    logic        sram_ready_in;
    logic [2:0]  wbuf_count_out;

    int total;
    int bad;

    sram_write_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_en_in            (wr_en_in),
        .rd_en_in            (rd_en_in),
        .address_in          (address_in),
        .write_data_in       (write_data_in),
        .ready_out           (ready_out),
        .read_data_out       (read_data_out),
        .sram_wr_en_out      (sram_wr_en_out),
        .sram_rd_en_out      (sram_rd_en_out),
        .sram_address_out    (sram_address_out),
        .sram_write_data_out (sram_write_data_out),
        .sram_read_data_in   (sram_read_data_in),
        .sram_ready_in       (sram_ready_in),
        .wbuf_count_out      (wbuf_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        sr;
        logic [63:0] srdata;
        logic        e_ready;
        logic        e_swr;
        logic        e_srd;
        logic [31:0] e_saddr;
        logic [31:0] e_sdata;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_in          = 1'b0;
        rd_en_in          = 1'b0;
        address_in        = '0;
        write_data_in     = '0;
        sram_ready_in     = 1'b0;
        sram_read_data_in = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d);
        wr_en_in      = 1'b1;
        address_in    = a;
        write_data_in = d;
    endtask

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // reset state, with a store request held to confirm ready stays low
        step();
        wr_en_in = 1'b1;
        #1;
        check("rst_ready", ready_out, 0);
        check("rst_swr", sram_wr_en_out, 0);
        check("rst_srd", sram_rd_en_out, 0);
        check("rst_saddr", sram_address_out, 0);
        check("rst_sdata", sram_write_data_out, 0);
        check("rst_cnt", wbuf_count_out, 0);
        wr_en_in = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // single store drain, then two stores ahead of a read miss
        vecs[0]  = '{1, 0, 32'h400, 32'hAAAA5555, 0, 64'h0,
                     1, 0, 0, 32'h0, 32'h0, 3'd0};
        vecs[1]  = '{0, 0, 32'h0, 32'h0, 0, 64'h0,
                     0, 1, 0, 32'h400, 32'hAAAA5555, 3'd1};
        vecs[2]  = '{0, 0, 32'h0, 32'h0, 0, 64'h0,
                     0, 1, 0, 32'h400, 32'hAAAA5555, 3'd1};
        vecs[3]  = '{0, 0, 32'h0, 32'h0, 1, 64'h0,
                     0, 1, 0, 32'h400, 32'hAAAA5555, 3'd1};
        vecs[4]  = '{0, 0, 32'h0, 32'h0, 0, 64'h0,
                     0, 0, 0, 32'h0, 32'h0, 3'd0};
        vecs[5]  = '{1, 0, 32'h100, 32'h11, 0, 64'h0,
                     1, 0, 0, 32'h0, 32'h0, 3'd0};
        vecs[6]  = '{1, 0, 32'h104, 32'h22, 0, 64'h0,
                     1, 1, 0, 32'h100, 32'h11, 3'd1};
        vecs[7]  = '{0, 1, 32'h408, 32'h0, 0, 64'h0,
                     0, 1, 0, 32'h100, 32'h11, 3'd2};
        vecs[8]  = '{0, 1, 32'h408, 32'h0, 1, 64'h0,
                     0, 1, 0, 32'h100, 32'h11, 3'd2};
        vecs[9]  = '{0, 1, 32'h408, 32'h0, 1, 64'h0,
                     0, 1, 0, 32'h104, 32'h22, 3'd1};
        vecs[10] = '{0, 1, 32'h408, 32'h0, 0, 64'h1122334455667788,
                     0, 0, 1, 32'h408, 32'h0, 3'd0};
        vecs[11] = '{0, 1, 32'h408, 32'h0, 1, 64'hDEADBEEFCAFEF00D,
                     1, 0, 1, 32'h408, 32'h0, 3'd0};
        vecs[12] = '{0, 0, 32'h0, 32'h0, 0, 64'h0,
                     0, 0, 0, 32'h0, 32'h0, 3'd0};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr && vecs[i].rd)
                $display("note: vector %0d drives store and read together", i);
            wr_en_in          = vecs[i].wr;
            rd_en_in          = vecs[i].rd;
            address_in        = vecs[i].addr;
            write_data_in     = vecs[i].data;
            sram_ready_in     = vecs[i].sr;
            sram_read_data_in = vecs[i].srdata;
            #1;
            check($sformatf("v%0d_ready", i), ready_out, vecs[i].e_ready);
            check($sformatf("v%0d_swr", i), sram_wr_en_out, vecs[i].e_swr);
            check($sformatf("v%0d_srd", i), sram_rd_en_out, vecs[i].e_srd);
            check($sformatf("v%0d_saddr", i), sram_address_out, vecs[i].e_saddr);
            check($sformatf("v%0d_sdata", i), sram_write_data_out, vecs[i].e_sdata);
            check($sformatf("v%0d_cnt", i), wbuf_count_out, vecs[i].e_cnt);
            if (vecs[i].e_ready && vecs[i].rd)
                check($sformatf("v%0d_rdata", i), read_data_out, vecs[i].srdata);
            step();
        end

        // five stores into a stalled SRAM: fifth waits for a pop
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            put_store(32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
            #1;
            check($sformatf("t2_acc%0d", i), ready_out, 1);
            step();
        end
        put_store(32'h410, 32'h1004);
        #1;
        check("t2_full_ready", ready_out, 0);
        check("t2_full_cnt", wbuf_count_out, 4);
        step();
        check("t2_full_ready2", ready_out, 0);
        step();
        sram_ready_in = 1'b1;
        #1;
        check("t2_full_pop_ready", ready_out, 0);
        check("t2_head_addr", sram_address_out, 32'h400);
        check("t2_head_data", sram_write_data_out, 32'h1000);
        step();
        sram_ready_in = 1'b0;
        #1;
        check("t2_fifth_ready", ready_out, 1);
        check("t2_head2_addr", sram_address_out, 32'h404);
        step();
        wr_en_in = 1'b0;
        for (int i = 1; i < 5; i++) begin
            sram_ready_in = 1'b1;
            #1;
            check($sformatf("t2_dr%0d_swr", i), sram_wr_en_out, 1);
            check($sformatf("t2_dr%0d_addr", i), sram_address_out,
                  32'h400 + 32'(4 * i));
            check($sformatf("t2_dr%0d_data", i), sram_write_data_out,
                  32'h1000 + 32'(i));
            step();
        end
        sram_ready_in = 1'b0;
        #1;
        check("t2_end_cnt", wbuf_count_out, 0);
        check("t2_end_swr", sram_wr_en_out, 0);

        // same-address store while the head is held on the SRAM bus
        reset_dut();
        put_store(32'h500, 32'h1);
        step();
        put_store(32'h504, 32'h2);
        step();
        put_store(32'h504, 32'h3);
        #1;
        check("t4_third_ready", ready_out, 1);
        step();
        wr_en_in = 1'b0;
        #1;
`ifdef WBUF_COALESCE_EN
        check("t4_cnt", wbuf_count_out, 2);
`else
        check("t4_cnt", wbuf_count_out, 3);
`endif
        got_a.delete();
        got_d.delete();
        sram_ready_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (sram_wr_en_out) begin
                got_a.push_back(sram_address_out);
                got_d.push_back(sram_write_data_out);
            end
            step();
        end
        sram_ready_in = 1'b0;
`ifdef WBUF_COALESCE_EN
        check("t4_nwr", got_a.size(), 2);
        if (got_a.size() == 2) begin
            check("t4_a0", got_a[0], 32'h500);
            check("t4_d0", got_d[0], 32'h1);
            check("t4_a1", got_a[1], 32'h504);
            check("t4_d1", got_d[1], 32'h3);
        end
`else
        check("t4_nwr", got_a.size(), 3);
        if (got_a.size() == 3) begin
            check("t4_a0", got_a[0], 32'h500);
            check("t4_d0", got_d[0], 32'h1);
            check("t4_a1", got_a[1], 32'h504);
            check("t4_d1", got_d[1], 32'h2);
            check("t4_a2", got_a[2], 32'h504);
            check("t4_d2", got_d[2], 32'h3);
        end
`endif

        // asynchronous reset in the middle of a drain
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            put_store(32'h600 + 32'(4 * i), 32'h60 + 32'(i));
            step();
        end
        wr_en_in = 1'b0;
        #1;
        check("t5_pre_cnt", wbuf_count_out, 3);
        check("t5_pre_swr", sram_wr_en_out, 1);
        #1;
        rst_n = 1'b0;
        wr_en_in = 1'b1;
        #1;
        check("t5_swr", sram_wr_en_out, 0);
        check("t5_cnt", wbuf_count_out, 0);
        check("t5_ready", ready_out, 0);
        wr_en_in = 1'b0;
        step();
        rst_n = 1'b1;
        sram_ready_in = 1'b1;
        begin
            int hi;
            hi = 0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (sram_wr_en_out || sram_rd_en_out) hi++;
                step();
            end
            check("t5_no_sram_ops", hi, 0);
        end
        check("t5_post_cnt", wbuf_count_out, 0);
        sram_ready_in = 1'b0;

        // twelve stores streamed through a throttled SRAM, pointers wrap
        reset_dut();
        got_a.delete();
        got_d.delete();
        begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            while (cyc < 200 && (n < 12 || wbuf_count_out != 0
                                 || sram_wr_en_out)) begin
                if (n < 12) put_store(32'h700 + 32'(4 * n), 32'h5000 + 32'(n));
                else wr_en_in = 1'b0;
                sram_ready_in = (cyc % 3) != 0;
                #1;
                if (sram_wr_en_out && sram_ready_in) begin
                    got_a.push_back(sram_address_out);
                    got_d.push_back(sram_write_data_out);
                end
                if (wr_en_in && ready_out) n++;
                step();
                cyc++;
            end
            check("t6_timeout", cyc < 200, 1);
            check("t6_accepted", n, 12);
        end
        wr_en_in = 1'b0;
        sram_ready_in = 1'b0;
        check("t6_nwr", got_a.size(), 12);
        for (int k = 0; k < 12 && k < got_a.size(); k++) begin
            check($sformatf("t6_a%0d", k), got_a[k], 32'h700 + 32'(4 * k));
            check($sformatf("t6_d%0d", k), got_d[k], 32'h5000 + 32'(k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
